pwm_capture: RTL and testbench

//   Servo-pulse decoder: measures the high time of an incoming servo PWM pulse and converts it

---
 rtl/servo_pkg.sv | 22 ++
 rtl/pwm_capture_div.sv | 54 +++++
 rtl/pwm_capture.sv | 193 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants, capture FSM state type and datapath widths.
// Used by the PWM generator and the pwm_capture decoder.
package servo_pkg;

    localparam int unsigned WAVELENGTH = 900_000;
    localparam int unsigned OFFSET     = 50_000;
    localparam int unsigned SDM        = 3125;
    localparam int unsigned SDD        = 16;
    localparam int unsigned TIMEOUT    = 2_000_000;

    localparam int POS_W = 8;
    localparam int NUM_W = 21;
    localparam int DEN_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        CALC,
        DONE
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_div.sv
// Eight-step restoring divider for the capture path.
// Quotient must fit in POS_W bits (num < 256*den).
module pwm_capture_div
    import servo_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic [POS_W-1:0] quo_o
);

    localparam int SH_W = (NUM_W > DEN_W + POS_W - 1) ? NUM_W : DEN_W + POS_W - 1;

    logic [SH_W-1:0]  rem_q;
    logic [SH_W-1:0]  dsh_q;
    logic [POS_W-1:0] quo_q;
    logic [2:0]       cnt_q;
    logic             busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= SH_W'(num_i);
            dsh_q  <= SH_W'(den_i) << (POS_W - 1);
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (rem_q >= dsh_q) begin
                rem_q <= rem_q - dsh_q;
                quo_q <= {quo_q[POS_W-2:0], 1'b1};
            end else begin
                quo_q <= {quo_q[POS_W-2:0], 1'b0};
            end
            dsh_q <= dsh_q >> 1;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Servo pulse decoder: high-time measurement back to an 8-bit position code.
// Define PWM_CAPTURE_FILTER_EN for a 4-sample glitch filter (latency 12 -> 16).
module pwm_capture
    import servo_pkg::*;
#(
    parameter int unsigned P_OFFSET  = servo_pkg::OFFSET,
    parameter int unsigned P_SDM     = servo_pkg::SDM,
    parameter int unsigned P_SDD     = servo_pkg::SDD,
    parameter int unsigned P_TIMEOUT = servo_pkg::TIMEOUT
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             pwm_i,
    output logic [POS_W-1:0] pos_o,
    output logic             valid_o,
    output logic             range_err_o,
    output logic             lost_o
);

    logic s1_q, s2_q, prev_q, rise_q, fall_q, lvl;

    // Synchroniser resets high so a pin already high at reset yields no rise.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= pwm_i;
            s2_q   <= s1_q;
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic       flt_q;
    logic [1:0] fcnt_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            flt_q  <= 1'b1;
            fcnt_q <= '0;
        end else if (s2_q == flt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == 2'd3) begin
            flt_q  <= s2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 2'd1;
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = s2_q;
`endif

    cap_state_e       state_q, state_d;
    logic [31:0]      w_q, w_d;
    logic [31:0]      idle_q, idle_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             lo_q, lo_d, hi_q, hi_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;

    logic             short_c, long_c, start_c;
    logic [39:0]      d_ext, num_ext;
    logic             div_busy;
    logic [POS_W-1:0] quo;

    always_comb begin
        short_c = w_q < (P_OFFSET + 32'd1);
        d_ext   = {8'd0, w_q} - 40'(P_OFFSET + 32'd1);
        num_ext = d_ext * 40'(P_SDD) + 40'(P_SDM / 2);
        long_c  = num_ext >= 40'(256 * P_SDM);
    end

    pwm_capture_div u_div (
        .clk_i   (clock_i),
        .rst_ni  (reset_n_i),
        .start_i (start_c),
        .num_i   (num_ext[NUM_W-1:0]),
        .den_i   (DEN_W'(P_SDM)),
        .busy_o  (div_busy),
        .quo_o   (quo)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pos_d   = pos_q;
        err_d   = err_q;
        valid_d = 1'b0;
        lost_d  = lost_q;
        start_c = 1'b0;

        if (rise_q) begin
            idle_d = '0;
        end else if (idle_q != P_TIMEOUT) begin
            idle_d = idle_q + 32'd1;
        end else begin
            idle_d = idle_q;
        end

        unique case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = HIGH;
                    w_d     = 32'd1;
                end
            end
            HIGH: begin
                if (fall_q) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    lo_d    = short_c;
                    hi_d    = !short_c && long_c;
                    start_c = !short_c && !long_c;
                end else if (w_q >= P_TIMEOUT) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end else if (w_q != '1) begin
                    w_d = w_q + 32'd1;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                err_d   = lo_q | hi_q;
                lost_d  = 1'b0;
                if (lo_q) begin
                    pos_d = '0;
                end else if (hi_q) begin
                    pos_d = '1;
                end else if (!div_busy) begin
                    pos_d = quo;
                end
            end
            default: state_d = IDLE;
        endcase

        if (idle_q == P_TIMEOUT) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            w_q     <= '0;
            idle_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= 1'b0;
            hi_q    <= 1'b0;
            pos_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    assign pos_o       = pos_q;
    assign valid_o     = valid_q;
    assign range_err_o = err_q;
    assign lost_o      = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with scaled-down timing parameters.
// Expected samples are queued on each fall; a negedge monitor pops on valid_o.
module tb_pwm_capture;

    localparam int OFS = 100;
    localparam int SDM = 50;
    localparam int SDD = 16;
    localparam int TMO = 3000;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 12;
`endif

    typedef struct {
        int pos;
        int err;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm = 1'b0;
    logic [7:0] pos_o;
    logic       valid_o;
    logic       range_err_o;
    logic       lost_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pwm_capture #(
        .P_OFFSET  (OFS),
        .P_SDM     (SDM),
        .P_SDD     (SDD),
        .P_TIMEOUT (TMO)
    ) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .pwm_i       (pwm),
        .pos_o       (pos_o),
        .valid_o     (valid_o),
        .range_err_o (range_err_o),
        .lost_o      (lost_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pos %0d err %0d expected none",
                         pos_o, range_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pos", int'(pos_o), e.pos);
                chk("range_err", int'(range_err_o), e.err);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High for exactly w clocks; exp_pos < 0 means no sample is expected.
    task automatic pulse(input int w, input int exp_pos, input int exp_err);
        exp_t e;
        @(negedge clk);
        pwm = 1'b1;
        wait_n(w);
        pwm = 1'b0;
        if (exp_pos >= 0) begin
            e.pos = exp_pos;
            e.err = exp_err;
            e.cyc = cyc + LAT + 1;
            exp_q.push_back(e);
        end
        wait_n(40);
    endtask

    initial begin
        wait_n(5);
        chk("rst_pos", int'(pos_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_err", int'(range_err_o), 0);
        chk("rst_lost", int'(lost_o), 0);
        rst_n = 1'b1;
        wait_n(10);

        pulse(101, 0, 0);
        pulse(501, 128, 0);
        pulse(897, 255, 0);
        pulse(80, 0, 1);
        pulse(100, 0, 1);
        pulse(899, 255, 0);
        pulse(900, 255, 1);
        pulse(1000, 255, 1);
        pulse(501, 128, 0);
        wait_n(30);
        chk("hold_pos", int'(pos_o), 128);
        chk("hold_err", int'(range_err_o), 0);

        for (int p = 0; p < 256; p += 17) begin
            pulse((p * SDM) / SDD + OFS + 1, p, 0);
        end

`ifdef PWM_CAPTURE_FILTER_EN
        pulse(3, -1, 0);
        pulse(4, 0, 1);
`else
        pulse(3, 0, 1);
`endif

        pulse(101, 0, 0);
        wait_n(2500);
        chk("lost_early", int'(lost_o), 0);
        wait_n(600);
        chk("lost_idle", int'(lost_o), 1);
        pulse(501, 128, 0);
        chk("lost_clear_idle", int'(lost_o), 0);

        @(negedge clk);
        pwm = 1'b1;
        wait_n(3100);
        chk("lost_stuck", int'(lost_o), 1);
        pwm = 1'b0;
        wait_n(50);
        chk("lost_after_stuck", int'(lost_o), 1);
        pulse(897, 255, 0);
        chk("lost_clear_stuck", int'(lost_o), 0);

        @(negedge clk);
        pwm = 1'b1;
        wait_n(200);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pos", int'(pos_o), 0);
        chk("mid_rst_err", int'(range_err_o), 0);
        chk("mid_rst_valid", int'(valid_o), 0);
        @(negedge clk);
        wait_n(3);
        rst_n = 1'b1;
        wait_n(100);
        pwm = 1'b0;
        wait_n(50);
        chk("mid_rst_hold", int'(pos_o), 0);
        pulse(501, 128, 0);

        wait_n(20);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
